seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Programmable, runtime-configurable serial bit-pattern detector with a control and sequencing wrapper.
- Generalises the fixed-pattern detectors in the codebase. Software loads the pattern, length, overlap mode and match target, then arms the block.
- The block qualifies the serial stream, counts matches, and stops itself when the target is reached.
- It sits between the serial input sampler and the status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- CNT_W, 8, width of the match counter and the target register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- cfg_we  input  1  loads the cfg_* fields into the shadow registers. Accepted only in IDLE or DONE; ignored in ARMED.
- cfg_pattern  input  MAX_LEN  pattern bits. Bit [cfg_len-1] is the first bit received; bit [0] is the last.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length. Legal range is 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  input  CNT_W  number of matches before auto-stop. 0 means unlimited.
- start  input  1  pulse that arms the detector from IDLE or DONE.
- abort  input  1  pulse that returns the block to IDLE from any state.
- in_valid  input  1  qualifies in. A bit is consumed only when in_valid=1 in ARMED.
- in  input  1  serial data bit.
- busy  output  1  high in ARMED.
- match  output  1  one-cycle pulse per detected pattern.
- match_count  output  CNT_W  matches since the last start.
- done  output  1  high in DONE; holds until start, abort or rst.
- cfg_err  output  1  sticky flag set by a start with an illegal length; cleared by cfg_we or rst.
- state  output  2  00 IDLE, 01 ARMED, 10 DONE. 11 is unused.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; busy=0, match=0, done=0, cfg_err=0, match_count=0.
  - History shift register and fill counter are cleared.
  - Shadow registers: pattern=0, len=1, overlap=1, target=0.
  - rst takes priority over every other input.
- State transitions:
  - IDLE + start, legal shadow len: go to ARMED. Clear match_count, history and fill.
  - IDLE + start, shadow len=0 or len>MAX_LEN: stay in IDLE and set cfg_err.
  - ARMED + start: start is ignored.
  - ARMED, matches reach target≠0: go to DONE on the same edge that registers the final match.
  - DONE + start: same handling as IDLE + start.
  - Any state + abort: go to IDLE. match_count is held; done clears. abort beats start in the same cycle.
- Shadow config is frozen while ARMED. cfg_we in ARMED is dropped silently. cfg_we and start in the same cycle in IDLE: the config is loaded first and start uses the new values.
- Consumed bit (ARMED and in_valid):
  - hist_next = {hist[MAX_LEN-2:0], in}.
  - fill_next = min(fill+1, MAX_LEN).
- Match condition: fill_next ≥ len and the low len bits of hist_next equal the low len bits of pattern.
- Match latency:
  - match is registered; it asserts in the cycle after the edge that consumed the completing bit.
  - match_count increments on that same edge and saturates at 2^CNT_W−1.
- Overlap mode:
  - overlap=1: history is kept after a match, so suffix reuse is allowed.
  - overlap=0: fill resets to 0 on the match edge, so the next match needs len fresh bits.
- in_valid=0: history, fill and match do not change (match=0). Gaps of any length are transparent.
- Bits arriving in IDLE or DONE are discarded. No match pulse can occur outside ARMED, and the final match pulse is still emitted in the cycle DONE is entered.

Test Plan:
- Overlapping 10101: pattern=5'b10101, len=5, overlap=1, target=0, start. Stream 1,0,1,0,1,0,1 with in_valid=1 → match pulses 1 cycle after bits 5 and 7; match_count=2.
- Non-overlapping, same stream: overlap=0 → a single match after bit 5; match_count=1; bits 6–7 do not match.
- Auto-stop: target=2, overlap=1. Stream 1010101010 → done=1 and state=10 in the cycle of the 2nd match. Later bits are ignored; match_count stays 2; start re-arms with count=0.
- Gaps and frozen config: same overlapping stream with in_valid=0 for 3 cycles between each bit → identical match count of 2. A cfg_we while ARMED changes nothing.
- Illegal start: len=0, start → state stays 00 and cfg_err=1. A following cfg_we with len=3 clears cfg_err.
- Abort and reset mid-run: abort after 3 bits of 10101 → IDLE with count held. Re-start, feed 1,0, then rst → all outputs at reset values. The next armed run requires a full 5 bits before any match.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Runtime-programmable serial pattern detector with arm / auto-stop control.
// Shadow config is frozen while armed; match is registered after the completing bit.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         busy,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic                         done,
    output logic                         cfg_err,
    output logic [1:0]                   state
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        DONE  = 2'b10
    } st_e;

    st_e st_q, st_d;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_inc;
    logic               match_q, err_q;

    logic               armed, cfg_ok, start_ok, len_legal;
    logic               consume, hit, tgt_hit;
    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] mask;

    assign armed     = (st_q == ARMED);
    assign cfg_ok    = cfg_we && !armed;
    // a start in the same cycle as cfg_we sees the freshly loaded length
    assign len_eff   = cfg_ok ? cfg_len : len_q;
    assign len_legal = (len_eff != '0) && (len_eff <= LEN_MAX);
    assign start_ok  = start && !abort && !armed;
    assign consume   = armed && in_valid && !abort;

    assign hist_d  = {hist_q[MAX_LEN-2:0], in};
    assign fill_d  = (fill_q == LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign hit = consume && (fill_d >= len_q)
              && (((hist_d ^ pat_q) & mask) == '0);
    assign tgt_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE, DONE: begin
                if (start && len_legal) st_d = ARMED;
            end
            ARMED: begin
                if (tgt_hit) st_d = DONE;
            end
            default: st_d = IDLE;
        endcase
        if (abort) st_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            ovl_q   <= 1'b1;
            tgt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (cfg_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end
            if (start_ok && !len_legal) begin
                err_q <= 1'b1;
            end else if (cfg_ok) begin
                err_q <= 1'b0;
            end
            match_q <= hit;
            if (start_ok && len_legal) begin
                cnt_q  <= '0;
                hist_q <= '0;
                fill_q <= '0;
            end else if (consume) begin
                hist_q <= hist_d;
                // non-overlap mode demands len fresh bits after each match
                fill_q <= (hit && !ovl_q) ? '0 : fill_d;
                if (hit) cnt_q <= cnt_inc;
            end
        end
    end

    always_comb begin
        busy        = (st_q == ARMED);
        done        = (st_q == DONE);
        state       = st_q;
        match       = match_q;
        match_count = cnt_q;
        cfg_err     = err_q;
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a behavioural model queues the
// expected post-edge outputs of every driven cycle; a monitor pops and compares.
module tb_seq_detect_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               in_valid = 1'b0;
    logic               in = 1'b0;
    logic               busy, match, done, cfg_err;
    logic [CNT_W-1:0]   match_count;
    logic [1:0]         state;

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .in_valid(in_valid), .in(in),
        .busy(busy), .match(match), .match_count(match_count),
        .done(done), .cfg_err(cfg_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             m;
        logic [CNT_W-1:0] c;
        logic [1:0]       s;
        logic             e;
        string            tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model state
    logic [MAX_LEN-1:0] m_pat;
    int m_len, m_tgt, m_st, m_cnt, m_fresh;
    bit m_ovl, m_err;
    bit m_bits[$];

    task automatic cyc(input string tag, input bit r, input bit we,
                       input bit st, input bit ab, input bit v, input bit b,
                       input logic [MAX_LEN-1:0] p, input int l,
                       input bit o, input int t);
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        rst = r; cfg_we = we; start = st; abort = ab;
        in_valid = v; in = b;
        cfg_pattern = p; cfg_len = LEN_W'(l);
        cfg_overlap = o; cfg_target = CNT_W'(t);
        if (r) begin
            m_st = 0; m_cnt = 0; m_err = 0; m_pat = '0; m_len = 1;
            m_ovl = 1; m_tgt = 0; m_fresh = 0; m_bits.delete();
        end else begin
            if (we && m_st != 1) begin
                m_pat = p; m_len = l; m_ovl = o; m_tgt = t; m_err = 0;
            end
            if (ab) begin
                m_st = 0;
            end else if (m_st != 1) begin
                if (st) begin
                    if (m_len >= 1 && m_len <= MAX_LEN) begin
                        m_st = 1; m_cnt = 0; m_fresh = 0; m_bits.delete();
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (v) begin
                m_bits.push_back(b);
                m_fresh++;
                if (m_fresh >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[m_bits.size()-1-k] != m_pat[k]) hit = 1'b0;
                end
                if (hit) begin
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (!m_ovl) m_fresh = 0;
                    if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
                end
            end
        end
        sb.push_back('{m: hit, c: CNT_W'(m_cnt), s: 2'(m_st),
                       e: m_err, tag: tag});
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic bitin(input string tag, input bit b);
        cyc(tag, 0, 0, 0, 0, 1, b, '0, 0, 0, 0);
    endtask

    task automatic arm(input string tag, input logic [MAX_LEN-1:0] p,
                       input int l, input bit o, input int t);
        cyc(tag, 0, 1, 1, 0, 0, 0, p, l, o, t);
    endtask

    task automatic load(input string tag, input logic [MAX_LEN-1:0] p,
                        input int l, input bit o, input int t);
        cyc(tag, 0, 1, 0, 0, 0, 0, p, l, o, t);
    endtask

    task automatic strt(input string tag);
        cyc(tag, 0, 0, 1, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic abrt(input string tag);
        cyc(tag, 0, 0, 0, 1, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic rst_cyc(input string tag);
        cyc(tag, 1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    // msb of s[n-1:0] is sent first, each bit followed by gaps idle cycles
    task automatic feed(input string tag, input logic [15:0] s,
                        input int n, input int gaps);
        logic [15:0] sv;
        sv = s;
        for (int i = n - 1; i >= 0; i--) begin
            bitin(tag, sv[i]);
            repeat (gaps) idle(tag);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, "/match"}, match, mon_e.m);
            check({mon_e.tag, "/count"}, match_count, mon_e.c);
            check({mon_e.tag, "/state"}, state, mon_e.s);
            check({mon_e.tag, "/busy"}, busy, mon_e.s == 2'b01);
            check({mon_e.tag, "/done"}, done, mon_e.s == 2'b10);
            check({mon_e.tag, "/err"}, cfg_err, mon_e.e);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_cyc("rst");
        rst_cyc("rst");
        @(posedge clk); #2;
        check("rst_state", state, 2'b00);
        check("rst_count", match_count, 0);
        check("rst_err", cfg_err, 0);
        check("rst_match", match, 0);

        arm("ov", 8'b10101, 5, 1, 0);
        feed("ov", 16'b1010101, 7, 0);
        @(posedge clk); #2;
        check("ov_count", match_count, 2);
        check("ov_busy", busy, 1);
        abrt("ov_abort");
        @(posedge clk); #2;
        check("abort_state", state, 2'b00);
        check("abort_held", match_count, 2);

        arm("nov", 8'b10101, 5, 0, 0);
        feed("nov", 16'b1010101, 7, 0);
        @(posedge clk); #2;
        check("nov_count", match_count, 1);
        abrt("nov_abort");

        arm("stop", 8'b10101, 5, 1, 2);
        feed("stop", 16'b1010101010, 10, 0);
        @(posedge clk); #2;
        check("stop_state", state, 2'b10);
        check("stop_done", done, 1);
        check("stop_count", match_count, 2);
        strt("rearm");
        @(posedge clk); #2;
        check("rearm_state", state, 2'b01);
        check("rearm_count", match_count, 0);
        abrt("rearm_abort");

        arm("gap", 8'b10101, 5, 1, 0);
        feed("gap", 16'b1010, 4, 3);
        load("frz", 8'b11, 2, 0, 1);
        feed("gap", 16'b101, 3, 3);
        @(posedge clk); #2;
        check("gap_count", match_count, 2);
        check("frz_state", state, 2'b01);
        abrt("gap_abort");

        load("bad", 8'b0, 0, 1, 0);
        strt("bad");
        @(posedge clk); #2;
        check("bad_state", state, 2'b00);
        check("bad_err", cfg_err, 1);
        load("fix", 8'b101, 3, 1, 0);
        @(posedge clk); #2;
        check("fix_err", cfg_err, 0);

        arm("ab", 8'b10101, 5, 1, 0);
        feed("ab", 16'b101, 3, 0);
        abrt("ab");
        strt("ab_re");
        feed("ab_re", 16'b10, 2, 0);
        rst_cyc("mid_rst");
        @(posedge clk); #2;
        check("mid_state", state, 2'b00);
        check("mid_count", match_count, 0);
        check("mid_busy", busy, 0);
        arm("post", 8'b10101, 5, 1, 0);
        feed("post", 16'b10101, 5, 0);
        @(posedge clk); #2;
        check("post_count", match_count, 1);
        abrt("post_abort");

        arm("len8", 8'b11010011, 8, 1, 0);
        feed("len8", 16'b1101001111010011, 16, 0);
        abrt("len8_abort");

        arm("sat", 8'b1, 1, 1, 0);
        repeat (260) bitin("sat", 1'b1);
        @(posedge clk); #2;
        check("sat_count", match_count, 255);

        idle("tail");
        idle("tail");
        @(posedge clk); #2;
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
